load_store_unit: RTL and testbench

- Multi-cycle initiator that sits between the execute stage and data_mem.
- Accepts one load/store request at a time from the core: byte, halfword or word access, signed or unsigned loads.
- Drives the word-addressed data memory's read_en, write_en, addr and write_data, and consumes its combinational read_data.
- Sub-word stores are done as a read-modify-write. Returns extended load data and a completion/error pulse.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: multi-cycle initiator between execute and a word-addressed data_mem.
// Ports: core req/op/addr/wdata in, ready/done/err/rdata out; mem_* drive data_mem, mem_read_data back.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [3:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q;
    state_e                acc_state_d;
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  op_ok;
    logic                  align_ok;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_d;
    logic [DATA_WIDTH-1:0] merge_d;
    logic                  rd_act;
    logic                  wr_act;

    // Legality of the incoming request, judged on the raw inputs at accept.
    always_comb begin
        op_ok    = 1'b0;
        align_ok = 1'b0;
        case (op[2:0])
            3'b000: begin
                op_ok    = 1'b1;
                align_ok = 1'b1;
            end
            3'b100: begin
                op_ok    = !op[3];
                align_ok = 1'b1;
            end
            3'b001: begin
                op_ok    = 1'b1;
                align_ok = !addr[0];
            end
            3'b101: begin
                op_ok    = !op[3];
                align_ok = !addr[0];
            end
            3'b011: begin
                op_ok    = 1'b1;
                align_ok = (addr[1:0] == 2'b00);
            end
            default: begin
                op_ok    = 1'b0;
                align_ok = 1'b0;
            end
        endcase
    end

    // Only word stores skip the read; sub-word stores need the old word.
    always_comb begin
        if (!(op_ok && align_ok)) begin
            acc_state_d = S_ERR;
        end else if (op[3] && (op[1:0] == 2'b11)) begin
            acc_state_d = S_WRITE;
        end else begin
            acc_state_d = S_READ;
        end
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_read_data[31:24];
            2'd1:    byte_lane = mem_read_data[23:16];
            2'd2:    byte_lane = mem_read_data[15:8];
            default: byte_lane = mem_read_data[7:0];
        endcase
        half_lane = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    end

    // op_q[2] selects zero extension.
    always_comb begin
        case (op_q[1:0])
            2'b00:   load_d = {{24{byte_lane[7] & ~op_q[2]}}, byte_lane};
            2'b01:   load_d = {{16{half_lane[15] & ~op_q[2]}}, half_lane};
            default: load_d = mem_read_data;
        endcase
    end

    always_comb begin
        merge_d = word_q;
        if (op_q[1:0] == 2'b11) begin
            merge_d = wdata_q;
        end else if (op_q[0]) begin
            if (addr_q[1]) begin
                merge_d[15:0] = wdata_q[15:0];
            end else begin
                merge_d[31:16] = wdata_q[15:0];
            end
        end else begin
            case (addr_q[1:0])
                2'd0:    merge_d[31:24] = wdata_q[7:0];
                2'd1:    merge_d[23:16] = wdata_q[7:0];
                2'd2:    merge_d[15:8]  = wdata_q[7:0];
                default: merge_d[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                S_READ: begin
                    if (op_q[3]) begin
                        word_q  <= mem_read_data;
                        state_q <= S_WRITE;
                    end else begin
                        rdata_q <= load_d;
                        state_q <= S_DONE;
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    // IDLE, DONE and ERR all accept a new request.
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        state_q <= acc_state_d;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Gating by rst keeps a reset in WRITE from committing a store.
    assign rd_act = !rst && (state_q == S_READ);
    assign wr_act = !rst && (state_q == S_WRITE);

    assign ready          = rst || (state_q == S_IDLE) ||
                            (state_q == S_DONE) || (state_q == S_ERR);
    assign done           = !rst && ((state_q == S_DONE) || (state_q == S_ERR));
    assign err            = !rst && (state_q == S_ERR);
    assign rdata          = rdata_q;
    assign mem_read_en    = rd_act;
    assign mem_write_en   = wr_act;
    assign mem_addr       = (rd_act || wr_act) ?
                            {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_write_data = wr_act ? merge_d : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-level reference memory.
// Driver pushes expected responses at accept; a negedge monitor pops on done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .op             (op),
        .addr           (addr),
        .wdata          (wdata),
        .ready          (ready),
        .done           (done),
        .err            (err),
        .rdata          (rdata),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    typedef struct {
        logic        e;
        logic [31:0] d;
        int          due;
        string       nm;
    } exp_t;

    logic [31:0] mem [64];
    logic [7:0]  refm [256];
    exp_t        sbq [$];
    exp_t        me;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_rd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;
    end

    assign mem_read_data = mem[mem_addr[7:2]];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read_en || mem_write_en) begin
                chk("en_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
                chk("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            end
            if (!mem_write_en) chk("wdata_idle_zero", mem_write_data, 32'd0);
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected none at cyc %0d", cyc);
                end else begin
                    me = sbq.pop_front();
                    chk({me.nm, " err"}, {31'd0, err}, {31'd0, me.e});
                    chk({me.nm, " rdata"}, rdata, me.d);
                    chk({me.nm, " latency"}, cyc, me.due);
                    if (me.e)
                        chk({me.nm, " no_mem"}, {31'd0, mem_read_en | mem_write_en}, 32'd0);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                checks++;
                fails++;
                $display("FAIL %s timeout: got no done expected at cyc %0d", sbq[0].nm, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    function automatic int sz(logic [2:0] o);
        case (o[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal(logic [3:0] o, logic [31:0] a);
        bit ok;
        case (o[2:0])
            3'b000, 3'b001, 3'b011: ok = 1'b1;
            3'b100, 3'b101:         ok = !o[3];
            default:                ok = 1'b0;
        endcase
        return ok && ((int'(a[7:0]) % sz(o[2:0])) == 0);
    endfunction

    task automatic send(string nm, logic [3:0] o, logic [31:0] a,
                        logic [31:0] wd, bit commit = 1'b1);
        exp_t        e;
        int          n;
        int          lat;
        bit          ok;
        bit          acc;
        logic [63:0] v;
        n = sz(o[2:0]);
        ok = legal(o, a);
        e.nm = nm;
        e.e = !ok;
        e.d = last_rd;
        if (ok && !o[3]) begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 64'(refm[int'(a[7:0]) + i]);
            if (!o[2] && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            e.d = v[31:0];
        end
        lat = !ok ? 1 : (!o[3] ? 2 : (n == 4 ? 2 : 3));
        acc = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            req = 1'b1;
            op = o;
            addr = a;
            wdata = wd;
            if (ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL %s accept: got ready=0 expected ready within 20 cycles", nm);
            req = 1'b0;
            return;
        end
        e.due = cyc + lat;
        sbq.push_back(e);
        if (ok && !o[3]) last_rd = e.d;
        if (ok && o[3] && commit)
            for (int i = 0; i < n; i++)
                refm[int'(a[7:0]) + i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            req = 1'b0;
        end
        if (sbq.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        idle(1);
    endtask

    task automatic preload(logic [31:0] a, logic [31:0] val);
        mem[a[7:2]] = val;
        for (int i = 0; i < 4; i++)
            refm[int'({a[7:2], 2'b00}) + i] = 8'(val >> (8 * (3 - i)));
    endtask

    initial begin
        bit          found;
        logic [3:0]  o;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        for (int i = 0; i < 256; i++) refm[i] = 8'd0;
        rst = 1'b1;
        req = 1'b0;
        op = 4'd0;
        addr = 32'd0;
        wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_write_data, 32'd0);

        send("sw_10", 4'b1011, 32'h10, 32'hDEADBEEF);
        send("lw_10", 4'b0011, 32'h10, 32'h0);
        drain();
        chk("sw_10 mem", mem[4], 32'hDEADBEEF);

        preload(32'h10, 32'h11223344);
        send("sb_11", 4'b1000, 32'h11, 32'h000000AA);
        send("lw_10b", 4'b0011, 32'h10, 32'h0);
        drain();
        chk("sb_11 mem", mem[4], 32'h11AA3344);

        preload(32'h20, 32'h80F07F01);
        send("lb_20", 4'b0000, 32'h20, 32'h0);
        send("lbu_20", 4'b0100, 32'h20, 32'h0);
        send("lh_20", 4'b0001, 32'h20, 32'h0);
        send("lhu_22", 4'b0101, 32'h22, 32'h0);
        send("lw_21", 4'b0011, 32'h21, 32'h0);
        send("sh_23", 4'b1001, 32'h23, 32'hFFFF);
        send("op_1100", 4'b1100, 32'h24, 32'hFF);
        send("op_0010", 4'b0010, 32'h24, 32'h0);
        drain();
        chk("err mem_24", mem[9], 32'd0);

        send("b2b_lb", 4'b0000, 32'h13, 32'h0);
        send("b2b_sw", 4'b1011, 32'h14, 32'h0BADF00D);
        send("b2b_lw", 4'b0011, 32'h14, 32'h0);
        send("pulse_lw", 4'b0011, 32'h20, 32'h0);
        @(negedge clk);
        req = 1'b1;
        op = 4'b1011;
        addr = 32'h40;
        wdata = 32'h55555555;
        chk("busy ready", {31'd0, ready}, 32'd0);
        idle(1);
        drain();
        chk("ignored mem_40", mem[16], 32'd0);

        preload(32'h30, 32'hCAFEF00D);
        send("sh_30_rst", 4'b1001, 32'h30, 32'h00001234, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem_write_en) begin
                found = 1'b1;
                rst = 1'b1;
                void'(sbq.pop_back());
                break;
            end
        end
        chk("rst write_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'd0;
        chk("post_rst ready", {31'd0, ready}, 32'd1);
        chk("post_rst rdata", rdata, 32'd0);
        chk("post_rst done", {31'd0, done}, 32'd0);
        chk("post_rst mem_30", mem[12], 32'hCAFEF00D);
        send("lh_30", 4'b0001, 32'h30, 32'h0);
        drain();

        for (int k = 0; k < 300; k++) begin
            o = 4'($urandom % 16);
            a = 32'($urandom_range(0, 255));
            if (($urandom % 4) != 0) a = a & ~32'(sz(o[2:0]) - 1);
            send("rnd", o, a, $urandom);
            if (($urandom % 3) == 0) idle($urandom_range(1, 2));
        end
        drain();

        for (int w = 0; w < 64; w++)
            chk("final_mem", mem[w],
                {refm[4*w], refm[4*w+1], refm[4*w+2], refm[4*w+3]});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
